// File: rtl/gray_pkg.sv
// Shared constants and Gray-code helpers for the Gray receive path.
// Helpers take a 32-bit zero-extended operand so one copy serves any width.
package gray_pkg;

  localparam int GRAY_W         = 4;
  localparam int SYNC_DEPTH_DEF = 2;

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic onehot_or_zero(input logic [31:0] x);
    return (x & (x - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/gray_sync_to_bin_sync_cell.sv
// Multi-bit flop chain used as the clock-domain-crossing synchroniser.
// No logic sits between stages; o_q is the last stage.
module gray_sync_cell #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_q[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_q[i] <= r_q[i-1];
      end
    end
  end

  assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/gray_sync_to_bin.sv
// Synchronises an async Gray bus and decodes it to binary with a change strobe.
// Define GRAY_SYNC_STEP_CHECK_EN to build the multi-bit step check and counter.
module gray_sync_to_bin
  import gray_pkg::*;
#(
  parameter int WIDTH       = GRAY_W,
  parameter int SYNC_STAGES = SYNC_DEPTH_DEF,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] G,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] B,
  output logic             B_VLD,
  output logic             STEP_ERR,
  output logic [CNT_W-1:0] ERR_CNT
);

  logic [WIDTH-1:0] w_gs;
  logic [WIDTH-1:0] w_bin;
  logic             w_chg;
  logic [WIDTH-1:0] r_gp;
  logic [WIDTH-1:0] r_b;
  logic             r_vld;

  gray_sync_cell #(
    .WIDTH (WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (CLK),
    .i_rst_n(RST_N),
    .i_d    (G),
    .o_q    (w_gs)
  );

  assign w_chg = (w_gs != r_gp);
  assign w_bin = WIDTH'(gray2bin(32'(w_gs)));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_gp  <= '0;
      r_b   <= '0;
      r_vld <= 1'b0;
    end else begin
      r_gp  <= w_gs;
      r_vld <= w_chg;
      if (w_chg) begin
        r_b <= w_bin;
      end
    end
  end

  assign B     = r_b;
  assign B_VLD = r_vld;

`ifdef GRAY_SYNC_STEP_CHECK_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_step;
  logic             r_step;
  logic [CNT_W-1:0] r_cnt;

  assign w_step = w_chg && !onehot_or_zero(32'(w_gs ^ r_gp));

  // Clear has priority over an error arriving on the same edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_step <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_step <= w_step;
      if (ERR_CLR) begin
        r_cnt <= '0;
      end else if (w_step && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign STEP_ERR = r_step;
  assign ERR_CNT  = r_cnt;
`else
  logic w_unused;

  assign w_unused = ERR_CLR;
  assign STEP_ERR = 1'b0;
  assign ERR_CNT  = '0;
`endif

endmodule

// File: tb/tb_gray_sync_to_bin.sv
// Directed self-checking bench for gray_sync_to_bin.
// Step-check expectations follow GRAY_SYNC_STEP_CHECK_EN.
module tb_gray_sync_to_bin;

  logic       CLK;
  logic       RST_N;
  logic [3:0] G;
  logic       ERR_CLR;
  logic [3:0] B;
  logic       B_VLD;
  logic       STEP_ERR;
  logic [7:0] ERR_CNT;

  int n_chk;
  int n_err;

`ifdef GRAY_SYNC_STEP_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  gray_sync_to_bin #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .CNT_W      (8)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .G       (G),
    .ERR_CLR (ERR_CLR),
    .B       (B),
    .B_VLD   (B_VLD),
    .STEP_ERR(STEP_ERR),
    .ERR_CNT (ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int pulses;
    int idx;
    logic [3:0] g;
    logic [3:0] seq_g [3];
    logic [3:0] seq_b [3];

    n_chk   = 0;
    n_err   = 0;
    RST_N   = 1'b0;
    G       = 4'b0000;
    ERR_CLR = 1'b0;
    #3;
    chk("rst_b",    32'(B),        32'h0);
    chk("rst_vld",  32'(B_VLD),    32'h0);
    chk("rst_step", 32'(STEP_ERR), 32'h0);
    chk("rst_cnt",  32'(ERR_CNT),  32'h0);

    steps(2);
    RST_N = 1'b1;
    steps(4);
    chk("idle_vld", 32'(B_VLD), 32'h0);

    // legal single-bit increments, each held 4 cycles
    seq_g[0] = 4'b0001; seq_b[0] = 4'b0001;
    seq_g[1] = 4'b0011; seq_b[1] = 4'b0010;
    seq_g[2] = 4'b0010; seq_b[2] = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      G = seq_g[k];
      step();
      chk("inc_vld_e1", 32'(B_VLD), 32'h0);
      step();
      chk("inc_vld_e2", 32'(B_VLD), 32'h0);
      step();
      chk("inc_vld_e3", 32'(B_VLD), 32'h1);
      chk("inc_b", 32'(B), 32'(seq_b[k]));
      chk("inc_step", 32'(STEP_ERR), 32'h0);
      step();
      chk("inc_vld_e4", 32'(B_VLD), 32'h0);
    end

    // full wrap 0..15 -> 0
    G = 4'b0000;
    steps(4);
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      idx = i % 16;
      g   = 4'(idx ^ (idx >> 1));
      G   = g;
      for (int c = 0; c < 3; c++) begin
        step();
        if (B_VLD) begin
          pulses++;
          chk("wrap_b", 32'(B), 32'(idx));
        end
      end
    end
    step();
    chk("wrap_pulses", 32'(pulses), 32'd16);
    chk("wrap_cnt", 32'(ERR_CNT), 32'h0);

    // multi-bit jump 0000 -> 0011
    G = 4'b0011;
    steps(3);
    chk("jmp_b",    32'(B),        32'h2);
    chk("jmp_vld",  32'(B_VLD),    32'h1);
    chk("jmp_step", 32'(STEP_ERR), 32'(CHK_EN));
    step();
    chk("jmp_step_off", 32'(STEP_ERR), 32'h0);
    chk("jmp_cnt", 32'(ERR_CNT), CHK_EN ? 32'd1 : 32'd0);

    // 300 further jumps saturate the counter
    for (int i = 0; i < 300; i++) begin
      G = (i % 2 == 0) ? 4'b0000 : 4'b0011;
      steps(2);
    end
    steps(4);
    chk("sat_cnt", 32'(ERR_CNT), CHK_EN ? 32'd255 : 32'd0);
    steps(3);
    chk("sat_hold", 32'(ERR_CNT), CHK_EN ? 32'd255 : 32'd0);

    // clear coinciding with an error
    G = 4'b0000;
    steps(2);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    chk("clr_step", 32'(STEP_ERR), 32'(CHK_EN));
    chk("clr_vld",  32'(B_VLD),    32'h1);
    chk("clr_cnt",  32'(ERR_CNT),  32'h0);
    G = 4'b0011;
    steps(4);
    chk("clr_recount", 32'(ERR_CNT), CHK_EN ? 32'd1 : 32'd0);

    // async reset mid-run with B = 1010
    G = 4'b1111;
    steps(4);
    chk("pre_rst_b", 32'(B), 32'hA);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_b",    32'(B),        32'h0);
    chk("mid_rst_vld",  32'(B_VLD),    32'h0);
    chk("mid_rst_step", 32'(STEP_ERR), 32'h0);
    chk("mid_rst_cnt",  32'(ERR_CNT),  32'h0);
    steps(2);
    RST_N = 1'b1;
    steps(3);
    chk("refill_b",    32'(B),        32'hA);
    chk("refill_vld",  32'(B_VLD),    32'h1);
    chk("refill_step", 32'(STEP_ERR), 32'(CHK_EN));
    step();
    chk("refill_cnt", 32'(ERR_CNT), CHK_EN ? 32'd1 : 32'd0);
    steps(5);
    chk("steady_vld", 32'(B_VLD), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gray_sync_to_bin.md
Name: gray_sync_to_bin

Overview:
- Receiving stage for the 4-bit Gray code produced by the existing binary-to-Gray converter.
- The Gray bus arrives from another clock domain. This block synchronises it into the local CLK domain and decodes it back to binary.
- Pulses a valid strobe on every decoded change.
- Optionally checks that consecutive samples differ by at most one bit, flagging and counting violations.
- Typical use: pointer/counter crossing, e.g. an async FIFO read/write pointer receiver.

Parameters:
- WIDTH, 4, Gray/binary bus width.
- SYNC_STAGES, 2, synchroniser flop depth; legal range >= 2.
- CNT_W, 8, width of the error counter.

Ports:
- CLK  input  1  local clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- G  input  WIDTH  Gray code from the upstream domain; treated as asynchronous.
- ERR_CLR  input  1  synchronous clear of ERR_CNT.
- B  output  WIDTH  decoded binary value, registered.
- B_VLD  output  1  one-cycle pulse when B takes a new value.
- STEP_ERR  output  1  one-cycle pulse when a multi-bit Gray jump is detected.
- ERR_CNT  output  CNT_W  saturating count of STEP_ERR events.

Behaviour:
- Reset (RST_N low, asynchronous): all synchroniser flops, the previous-sample register, B, B_VLD, STEP_ERR and ERR_CNT go to 0.
- Reset release: the first compare is against Gray 0.
- Synchroniser:
  - G passes through SYNC_STAGES flops; no logic between them.
  - The last stage is gs. Only gs is used downstream.
- Previous sample: gp <= gs every cycle.
- Change detect: chg = (gs != gp).
- Decode: bin[WIDTH-1] = gs[WIDTH-1]; bin[i] = bin[i+1] ^ gs[i] for i = WIDTH-2 down to 0. Exact inverse of the upstream encoder.
- Output register: on the cycle chg is high, B <= bin(gs) and B_VLD <= 1. Otherwise B holds and B_VLD <= 0.
- Latency:
  - A G change sampled at edge k is in gs at edge k+SYNC_STAGES-1.
  - B/B_VLD update at edge k+SYNC_STAGES, i.e. 3 edges for the default.
- Steady input: B_VLD stays 0 indefinitely. No pulse is generated without a change.
- Step check (gs ^ gp has popcount > 1):
  - STEP_ERR <= 1 for one cycle, aligned with B_VLD.
  - B still updates to the decoded value; no filtering.
- Wrap-around: Gray 1000 -> 0000 (binary 15 -> 0) is a one-bit change and is not an error.
- ERR_CNT:
  - Increments on each STEP_ERR assertion and saturates at 2^CNT_W-1.
  - ERR_CLR high forces it to 0 on the next edge. Clear wins over a simultaneous error.
- Skipped values: skipped Gray values that still arrive as a single-bit difference are not detectable and are not flagged.
- Reset mid-operation: outputs clear immediately. After release, the sync pipeline refills; the first non-zero gs produces B_VLD, plus STEP_ERR if more than one bit is set.

Optional Feature:
- Macro: GRAY_SYNC_STEP_CHECK_EN.
- Defined: popcount compare, STEP_ERR and ERR_CNT are implemented as described above.
- Undefined:
  - Step-check logic and counter are not built.
  - STEP_ERR and ERR_CNT are tied to 0; ERR_CLR is ignored.
  - B/B_VLD behaviour is unchanged.

Decomposition:
- Package gray_pkg holds:
  - default constants GRAY_W = 4 and SYNC_DEPTH_DEF = 2;
  - function gray2bin(width-generic loop);
  - function onehot_or_zero for the step check.
- One sub-module: gray_sync_cell, a SYNC_STAGES-deep multi-bit flop chain with async active-low reset.
- Decode, compare and counter stay in the top level.

Test Plan:
- Reset check: assert RST_N=0 mid-run with B=1010 -> B, B_VLD, STEP_ERR, ERR_CNT read 0 before the next CLK edge.
- Legal increment: G 0000 -> 0001 -> 0011 -> 0010, each held 4 cycles -> B = 0001, 0010, 0011, each exactly 3 edges after the change; one B_VLD pulse each; STEP_ERR never high.
- Wrap-around: drive the full Gray sequence 0000..1000 -> 0000 -> B counts 0..15 -> 0; 16 B_VLD pulses; ERR_CNT stays 0.
- Multi-bit jump: G 0000 -> 0011 -> B = 0010, B_VLD and STEP_ERR both pulse on the same cycle; ERR_CNT = 1.
- Saturation and clear: 300 alternating 0000/0011 jumps -> ERR_CNT = 255 and holds. ERR_CLR pulsed on the same cycle as a further error -> ERR_CNT = 0.
- Macro off: repeat the multi-bit jump test without GRAY_SYNC_STEP_CHECK_EN -> B = 0010, B_VLD pulses, STEP_ERR = 0, ERR_CNT = 0.
